// File: rtl/cpu_pkg.sv
// Shared types and constants for the control sequencer: state encoding,
// bus source selects, opcode classes and the registered control word.
package cpu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_T0   = 3'd1,
        ST_T1   = 3'd2,
        ST_T2   = 3'd3,
        ST_T3   = 3'd4,
        ST_T4   = 3'd5,
        ST_T5   = 3'd6,
        ST_T6   = 3'd7
    } state_t;

    typedef enum logic [1:0] {
        CLS_ALU     = 2'd0,
        CLS_MULDIV  = 2'd1,
        CLS_ILLEGAL = 2'd2
    } op_class_t;

    localparam logic [4:0] SRC_HI  = 5'b10000;
    localparam logic [4:0] SRC_LO  = 5'b10001;
    localparam logic [4:0] SRC_ZHI = 5'b10010;
    localparam logic [4:0] SRC_ZLO = 5'b10011;
    localparam logic [4:0] SRC_PC  = 5'b10100;
    localparam logic [4:0] SRC_MDR = 5'b10101;

    localparam logic [4:0] OP_ALU_LAST = 5'h0B;
    localparam logic [4:0] OP_MUL      = 5'h0F;
    localparam logic [4:0] OP_DIV      = 5'h10;

    localparam logic [3:0] ALU_MUL = 4'b1111;
    localparam logic [3:0] ALU_DIV = 4'b1110;

    typedef struct packed {
        op_class_t  cls;
        logic [3:0] ra;
        logic [3:0] rb;
        logic [3:0] rc;
        logic [3:0] alu_op;
    } decode_t;

    typedef struct packed {
        logic [4:0] bus_sel;
        logic [3:0] gp_addr;
        logic [3:0] alu_op;
        logic       e_pc;
        logic       e_ir;
        logic       e_y;
        logic       e_z;
        logic       e_hi;
        logic       e_lo;
        logic       e_mdr;
        logic       e_mar;
        logic       e_gp;
        logic       inc_pc;
        logic       mdr_read;
        logic       done;
        logic       illegal;
        logic       mem_fault;
    } ctrl_t;

    // General-purpose registers occupy bus selects 0-15.
    function automatic logic [4:0] gp_src(input logic [3:0] r);
        return {1'b0, r};
    endfunction

endpackage

// File: rtl/instr_decode.sv
// Combinational instruction decoder: IR to opcode class, register fields and ALU op.
module instr_decode
    import cpu_pkg::*;
(
    input  logic [31:0] ir,
    output decode_t     dec_c
);

    logic [4:0] opcode;
    logic       unused_ir_low;

    assign opcode        = ir[31:27];
    assign unused_ir_low = ^ir[14:0];

    always_comb begin
        dec_c        = '0;
        dec_c.cls    = CLS_ILLEGAL;
        dec_c.ra     = ir[26:23];
        dec_c.rb     = ir[22:19];
        dec_c.rc     = ir[18:15];
        if (opcode <= OP_ALU_LAST) begin
            dec_c.cls    = CLS_ALU;
            dec_c.alu_op = opcode[3:0];
        end else if (opcode == OP_MUL) begin
            dec_c.cls    = CLS_MULDIV;
            dec_c.alu_op = ALU_MUL;
        end else if (opcode == OP_DIV) begin
            dec_c.cls    = CLS_MULDIV;
            dec_c.alu_op = ALU_DIV;
        end
    end

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle fetch/execute control sequencer. Control outputs are registered
// and reflect the state entered at each clock edge.
module control_sequencer
    import cpu_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        run,
    input  logic [31:0] IR,
    input  logic        mem_ready,
    output logic [4:0]  BusDataSelect,
    output logic [3:0]  GP_addr,
    output logic        e_PC,
    output logic        e_IR,
    output logic        e_Y,
    output logic        e_Z,
    output logic        e_HI,
    output logic        e_LO,
    output logic        e_MDR,
    output logic        e_MAR,
    output logic        e_GP,
    output logic        incPC,
    output logic        MDR_read,
    output logic [3:0]  ALU_op,
    output logic        done,
    output logic        illegal,
    output logic        mem_fault
);

    localparam int unsigned WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    state_t            state;
    state_t            state_nxt_c;
    logic [WAIT_W-1:0] wait_cnt;
    ctrl_t             ctrl_q;
    decode_t           dec_c;

    instr_decode u_decode (
        .ir    (IR),
        .dec_c (dec_c)
    );

    // Control word for the state being entered.
    function automatic ctrl_t ctrl_for(input state_t s, input decode_t d,
                                       input logic first_t1, input logic fault);
        ctrl_t c;
        c = '0;
        case (s)
            ST_IDLE: c.mem_fault = fault;
            ST_T0: begin
                c.bus_sel = SRC_PC;
                c.e_mar   = 1'b1;
                c.inc_pc  = 1'b1;
                c.e_z     = 1'b1;
            end
            ST_T1: begin
                c.bus_sel  = SRC_ZLO;
                c.e_pc     = first_t1;
                c.mdr_read = 1'b1;
                c.e_mdr    = 1'b1;
            end
            ST_T2: begin
                c.bus_sel = SRC_MDR;
                c.e_ir    = 1'b1;
            end
            ST_T3: begin
                if (d.cls == CLS_ILLEGAL) begin
                    c.illegal = 1'b1;
                end else begin
                    c.bus_sel = gp_src(d.rb);
                    c.e_y     = 1'b1;
                end
            end
            ST_T4: begin
                c.bus_sel = gp_src(d.rc);
                c.alu_op  = d.alu_op;
                c.e_z     = 1'b1;
            end
            ST_T5: begin
                c.bus_sel = SRC_ZLO;
                if (d.cls == CLS_ALU) begin
                    c.gp_addr = d.ra;
                    c.e_gp    = 1'b1;
                    c.done    = 1'b1;
                end else begin
                    c.e_lo = 1'b1;
                end
            end
            ST_T6: begin
                c.bus_sel = SRC_ZHI;
                c.e_hi    = 1'b1;
                c.done    = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        state_nxt_c = state;
        case (state)
            ST_IDLE: state_nxt_c = run ? ST_T0 : ST_IDLE;
            ST_T0:   state_nxt_c = ST_T1;
            ST_T1: begin
                if (mem_ready)
                    state_nxt_c = ST_T2;
                else if (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1))
                    state_nxt_c = ST_IDLE;
            end
            ST_T2:   state_nxt_c = ST_T3;
            ST_T3:   state_nxt_c = (dec_c.cls == CLS_ILLEGAL) ? (run ? ST_T0 : ST_IDLE) : ST_T4;
            ST_T4:   state_nxt_c = ST_T5;
            ST_T5:   state_nxt_c = (dec_c.cls == CLS_ALU) ? (run ? ST_T0 : ST_IDLE) : ST_T6;
            ST_T6:   state_nxt_c = run ? ST_T0 : ST_IDLE;
            default: state_nxt_c = ST_IDLE;
        endcase
    end

    // Wait counter only survives T1-to-T1; any other transition zeroes it.
    always_ff @(posedge clock) begin
        if (!clear) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
            ctrl_q   <= '0;
        end else begin
            state    <= state_nxt_c;
            wait_cnt <= (state == ST_T1 && state_nxt_c == ST_T1) ? wait_cnt + WAIT_W'(1) : '0;
            ctrl_q   <= ctrl_for(state_nxt_c, dec_c, state == ST_T0,
                                 state == ST_T1 && state_nxt_c == ST_IDLE);
        end
    end

    assign BusDataSelect = ctrl_q.bus_sel;
    assign GP_addr       = ctrl_q.gp_addr;
    assign ALU_op        = ctrl_q.alu_op;
    assign e_PC          = ctrl_q.e_pc;
    assign e_IR          = ctrl_q.e_ir;
    assign e_Y           = ctrl_q.e_y;
    assign e_Z           = ctrl_q.e_z;
    assign e_HI          = ctrl_q.e_hi;
    assign e_LO          = ctrl_q.e_lo;
    assign e_MDR         = ctrl_q.e_mdr;
    assign e_MAR         = ctrl_q.e_mar;
    assign e_GP          = ctrl_q.e_gp;
    assign incPC         = ctrl_q.inc_pc;
    assign MDR_read      = ctrl_q.mdr_read;
    assign done          = ctrl_q.done;
    assign illegal       = ctrl_q.illegal;
    assign mem_fault     = ctrl_q.mem_fault;

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized bench: builds the expected per-cycle control trace of each
// instruction from its fields, then drives the sequencer and compares every cycle.
module tb_control_sequencer;

    localparam int unsigned TMO = 15;

    localparam logic [13:0] F_PC   = 14'h2000;
    localparam logic [13:0] F_IR   = 14'h1000;
    localparam logic [13:0] F_Y    = 14'h0800;
    localparam logic [13:0] F_Z    = 14'h0400;
    localparam logic [13:0] F_HI   = 14'h0200;
    localparam logic [13:0] F_LO   = 14'h0100;
    localparam logic [13:0] F_MDR  = 14'h0080;
    localparam logic [13:0] F_MAR  = 14'h0040;
    localparam logic [13:0] F_GP   = 14'h0020;
    localparam logic [13:0] F_INC  = 14'h0010;
    localparam logic [13:0] F_MRD  = 14'h0008;
    localparam logic [13:0] F_DONE = 14'h0004;
    localparam logic [13:0] F_ILL  = 14'h0002;
    localparam logic [13:0] F_FLT  = 14'h0001;

    logic        clock = 1'b0;
    logic        clear;
    logic        run;
    logic [31:0] IR;
    logic        mem_ready;
    logic [4:0]  BusDataSelect;
    logic [3:0]  GP_addr;
    logic        e_PC, e_IR, e_Y, e_Z, e_HI, e_LO, e_MDR, e_MAR, e_GP, incPC, MDR_read;
    logic [3:0]  ALU_op;
    logic        done, illegal, mem_fault;

    int checks   = 0;
    int failures = 0;
    bit idle     = 1'b1;

    logic [26:0] exp_q[$];
    bit          rdy_q[$];

    control_sequencer #(.MEM_TIMEOUT(TMO)) dut (
        .clock         (clock),
        .clear         (clear),
        .run           (run),
        .IR            (IR),
        .mem_ready     (mem_ready),
        .BusDataSelect (BusDataSelect),
        .GP_addr       (GP_addr),
        .e_PC          (e_PC),
        .e_IR          (e_IR),
        .e_Y           (e_Y),
        .e_Z           (e_Z),
        .e_HI          (e_HI),
        .e_LO          (e_LO),
        .e_MDR         (e_MDR),
        .e_MAR         (e_MAR),
        .e_GP          (e_GP),
        .incPC         (incPC),
        .MDR_read      (MDR_read),
        .ALU_op        (ALU_op),
        .done          (done),
        .illegal       (illegal),
        .mem_fault     (mem_fault)
    );

    always #5 clock = ~clock;

    function automatic logic [26:0] obs();
        return {BusDataSelect, GP_addr, ALU_op, e_PC, e_IR, e_Y, e_Z, e_HI, e_LO,
                e_MDR, e_MAR, e_GP, incPC, MDR_read, done, illegal, mem_fault};
    endfunction

    function automatic logic [26:0] vec(input logic [4:0] bus, input logic [3:0] gp,
                                        input logic [3:0] alu, input logic [13:0] fl);
        return {bus, gp, alu, fl};
    endfunction

    task automatic check_val(input string tag, input logic [26:0] got, input logic [26:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Expected trace of one instruction, one entry per cycle starting at T0.
    task automatic build_trace(input logic [4:0] op, input logic [3:0] ra, input logic [3:0] rb,
                               input logic [3:0] rc, input int delay);
        bit          is_alu, is_md, fault;
        int          n1;
        logic [3:0]  op_lo;
        logic [13:0] t1f;
        exp_q.delete();
        rdy_q.delete();
        is_alu = (op <= 5'h0B);
        is_md  = (op == 5'h0F) || (op == 5'h10);
        fault  = (delay >= int'(TMO));
        n1     = fault ? int'(TMO) : delay + 1;
        op_lo  = op[3:0];
        exp_q.push_back(vec(5'h14, 4'h0, 4'h0, F_MAR | F_INC | F_Z));
        rdy_q.push_back(1'($urandom));
        for (int j = 0; j < n1; j++) begin
            t1f = F_MRD | F_MDR;
            if (j == 0) t1f = t1f | F_PC;
            exp_q.push_back(vec(5'h13, 4'h0, 4'h0, t1f));
            rdy_q.push_back(!fault && j == delay);
        end
        if (fault) begin
            exp_q.push_back(vec(5'h00, 4'h0, 4'h0, F_FLT));
            rdy_q.push_back(1'($urandom));
            return;
        end
        exp_q.push_back(vec(5'h15, 4'h0, 4'h0, F_IR));
        rdy_q.push_back(1'($urandom));
        if (!is_alu && !is_md) begin
            exp_q.push_back(vec(5'h00, 4'h0, 4'h0, F_ILL));
            rdy_q.push_back(1'($urandom));
            return;
        end
        exp_q.push_back(vec({1'b0, rb}, 4'h0, 4'h0, F_Y));
        rdy_q.push_back(1'($urandom));
        exp_q.push_back(vec({1'b0, rc}, 4'h0,
                            is_alu ? op_lo : ((op == 5'h0F) ? 4'hF : 4'hE), F_Z));
        rdy_q.push_back(1'($urandom));
        if (is_alu) begin
            exp_q.push_back(vec(5'h13, ra, 4'h0, F_GP | F_DONE));
            rdy_q.push_back(1'($urandom));
        end else begin
            exp_q.push_back(vec(5'h13, 4'h0, 4'h0, F_LO));
            rdy_q.push_back(1'($urandom));
            exp_q.push_back(vec(5'h12, 4'h0, 4'h0, F_HI | F_DONE));
            rdy_q.push_back(1'($urandom));
        end
    endtask

    // drop_at < 0 keeps run high; clear_at >= 0 pulls clear low in that cycle.
    task automatic do_instr(input logic [4:0] op, input logic [3:0] ra, input logic [3:0] rb,
                            input logic [3:0] rc, input int delay, input int drop_at,
                            input int clear_at, input string tag);
        build_trace(op, ra, rb, rc, delay);
        if (idle) run = 1'b1;
        for (int i = 0; i < exp_q.size(); i++) begin
            @(posedge clock);
            #1;
            check_val($sformatf("%s c%0d", tag, i), obs(), exp_q[i]);
            if (i == 0) IR = {op, ra, rb, rc, 15'($urandom)};
            mem_ready = rdy_q[i];
            run       = (drop_at < 0) || (i < drop_at);
            if (i == clear_at) begin
                clear = 1'b0;
                @(posedge clock);
                #1;
                check_val($sformatf("%s clear", tag), obs(), 27'h0);
                clear = 1'b1;
                run   = 1'b0;
                idle  = 1'b1;
                return;
            end
        end
        if (!run) begin
            @(posedge clock);
            #1;
            check_val($sformatf("%s idle", tag), obs(), 27'h0);
            idle = 1'b1;
        end else begin
            idle = 1'b0;
        end
    endtask

    initial begin
        logic [4:0] op;
        int         r, delay, drop_at, clear_at;
        clear     = 1'b0;
        run       = 1'b0;
        mem_ready = 1'b0;
        IR        = 32'h0;
        repeat (2) @(posedge clock);
        #1;
        check_val("reset", obs(), 27'h0);
        run = 1'b1;
        @(posedge clock);
        #1;
        check_val("reset_run", obs(), 27'h0);
        clear = 1'b1;
        run   = 1'b0;
        idle  = 1'b1;

        do_instr(5'h04, 4'd4, 4'd3, 4'd7, 0, -1, -1, "alu04");
        do_instr(5'h0F, 4'd1, 4'd2, 4'd5, 0, -1, -1, "mul");
        do_instr(5'h10, 4'd9, 4'd6, 4'd8, 0, -1, -1, "div");
        do_instr(5'h02, 4'd1, 4'd2, 4'd3, 3, -1, -1, "wait3");
        do_instr(5'h0B, 4'd15, 4'd14, 4'd13, int'(TMO) - 1, -1, -1, "wait_edge");
        do_instr(5'h1F, 4'd5, 4'd6, 4'd7, 0, -1, -1, "illegal");
        do_instr(5'h03, 4'd1, 4'd1, 4'd1, int'(TMO), 1, -1, "timeout");
        do_instr(5'h06, 4'd2, 4'd3, 4'd4, 0, -1, 4, "clear_t4");
        do_instr(5'h07, 4'd8, 4'd9, 4'd10, 0, 2, -1, "drop_t2");
        do_instr(5'h08, 4'd1, 4'd2, 4'd3, 10, -1, 5, "clear_wait");
        do_instr(5'h00, 4'd0, 4'd0, 4'd0, 0, 0, -1, "drop_t0");

        for (int n = 0; n < 60; n++) begin
            r = int'($urandom_range(0, 9));
            if (r < 6) begin
                op = 5'($urandom_range(0, 11));
            end else if (r < 8) begin
                op = (r == 6) ? 5'h0F : 5'h10;
            end else begin
                do op = 5'($urandom); while (op <= 5'h0B || op == 5'h0F || op == 5'h10);
            end
            r = int'($urandom_range(0, 9));
            if (r < 7)       delay = int'($urandom_range(0, 3));
            else if (r == 7) delay = int'(TMO) - 1;
            else if (r == 8) delay = int'(TMO);
            else             delay = int'($urandom_range(0, TMO - 2));
            drop_at  = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, 20));
            clear_at = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 8)) : -1;
            do_instr(op, 4'($urandom), 4'($urandom), 4'($urandom), delay, drop_at, clear_at,
                     $sformatf("rnd%0d", n));
        end

        if (!idle) begin
            run = 1'b0;
            do_instr(5'h01, 4'd1, 4'd2, 4'd3, 0, 0, -1, "final");
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
